// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU flag layout and default datapath width
package alu_pkg;

  localparam int ALU_W  = 16;
  localparam int FLAG_W = 4;

  // Flag bit positions within a {Z,N,C,V} nibble
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - derives {Z,N,C,V} from an ALU result word
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0]  data,
  input  logic              carry,
  input  logic              ovf,
  output logic [FLAG_W-1:0] flags
);

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = ~|data;
    flags[FLAG_N] = data[WIDTH-1];
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - FIFO holding ALU results with captured flags
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_carry,
  input  logic                     in_ovf,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [FLAG_W-1:0]        out_flags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + FLAG_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [FLAG_W-1:0] cap_flags;
  logic [EW-1:0]     head;
  logic              wr_en;
  logic              rd_en;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .data  (in_data),
    .carry (in_carry),
    .ovf   (in_ovf),
    .flags (cap_flags)
  );

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes them wrap on their own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= {in_data, cap_flags};
  end

  // Storage is never reset, so mask the head whenever nothing valid is held
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[EW-1:FLAG_W] : '0;
  assign out_flags = out_valid ? head[FLAG_W-1:0]  : '0;
  assign count     = count_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - self-checking bench for alu_result_buffer
module tb_alu_result_buffer;

  localparam int W = 16;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_carry = 1'b0;
  logic          in_ovf = 1'b0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [3:0]    out_flags;
  logic [2:0]    count;

  int nvec = 0;
  int nerr = 0;
  bit saw_beef = 1'b0;

  typedef struct {
    logic [W-1:0] d;
    logic [3:0]   f;
  } entry_t;
  entry_t q[$];

  alu_result_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_carry  (in_carry),
    .in_ovf    (in_ovf),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_flags(logic [W-1:0] d, logic c, logic v);
    return {(d == 0), d[W-1], c, v};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue following the accept/take/flush rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      bit wr, rd;
      entry_t e;
      wr = in_valid && (q.size() < D);
      rd = out_ready && (q.size() > 0);
      e.d = in_data;
      e.f = exp_flags(in_data, in_carry, in_ovf);
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(e);
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() != D));
    chk("count", 32'(count), 32'(q.size()));
    if (q.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_flags", 32'(out_flags), 32'(q[0].f));
    end
    if (!rst_n) begin
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_flags", 32'(out_flags), 32'h0);
    end
    if (out_valid && out_data == 16'hBEEF) saw_beef = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(logic [W-1:0] d, logic c, logic v);
    in_valid = 1'b1;
    in_data  = d;
    in_carry = c;
    in_ovf   = v;
    tick();
    in_valid = 1'b0;
    in_carry = 1'b0;
    in_ovf   = 1'b0;
  endtask

  task automatic drain(int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  logic [W-1:0] exp_d [4];
  logic [3:0]   exp_f [4];

  initial begin
    exp_d[0] = 16'h8001; exp_f[0] = 4'b0110;
    exp_d[1] = 16'h0001; exp_f[1] = 4'b0000;
    exp_d[2] = 16'h7FFF; exp_f[2] = 4'b0001;
    exp_d[3] = 16'h1234; exp_f[3] = 4'b0000;

    repeat (3) tick();
    chk("lit_rst_count", 32'(count), 32'h0);
    chk("lit_rst_valid", 32'(out_valid), 32'h0);
    chk("lit_rst_ready", 32'(in_ready), 32'h1);
    chk("lit_rst_data", 32'(out_data), 32'h0);
    #2 rst_n = 1'b1;

    // Single zero write right after reset release
    put(16'h0000, 1'b0, 1'b0);
    chk("lit_single_valid", 32'(out_valid), 32'h1);
    chk("lit_single_data", 32'(out_data), 32'h0);
    chk("lit_single_flags", 32'(out_flags), 32'b1000);
    chk("lit_single_count", 32'(count), 32'h1);
    drain(1);

    // Fill then drain in order
    put(16'h8001, 1'b1, 1'b0);
    put(16'h0001, 1'b0, 1'b0);
    put(16'h7FFF, 1'b0, 1'b1);
    put(16'h1234, 1'b0, 1'b0);
    chk("lit_fill_count", 32'(count), 32'h4);
    chk("lit_fill_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("lit_drain_data", 32'(out_data), 32'(exp_d[i]));
      chk("lit_drain_flags", 32'(out_flags), 32'(exp_f[i]));
      drain(1);
    end
    chk("lit_drain_empty", 32'(count), 32'h0);

    // Full: read with a blocked write, write lands next cycle
    put(16'h0011, 1'b0, 1'b0);
    put(16'h0022, 1'b0, 1'b0);
    put(16'h0033, 1'b0, 1'b0);
    put(16'h0044, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data = 16'h0055;
    out_ready = 1'b1;
    tick();
    chk("lit_full_count3", 32'(count), 32'h3);
    chk("lit_full_head", 32'(out_data), 32'h0022);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("lit_full_count4", 32'(count), 32'h4);
    for (int i = 0; i < 4; i++) drain(1);
    chk("lit_full_empty", 32'(count), 32'h0);

    // Streaming 1..10 with both sides always ready
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = 16'(i);
      tick();
      chk("lit_stream_count", 32'(count), 32'h1);
      chk("lit_stream_data", 32'(out_data), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("lit_stream_empty", 32'(count), 32'h0);

    // Flush beats a same-cycle write
    put(16'h00A1, 1'b0, 1'b0);
    put(16'h00A2, 1'b0, 1'b0);
    chk("lit_flush_pre", 32'(count), 32'h2);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 16'hBEEF;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("lit_flush_count", 32'(count), 32'h0);
    chk("lit_flush_valid", 32'(out_valid), 32'h0);
    repeat (3) tick();

    // Asynchronous reset between edges
    put(16'h0101, 1'b0, 1'b0);
    put(16'h0202, 1'b0, 1'b0);
    put(16'h0303, 1'b0, 1'b0);
    chk("lit_arst_pre", 32'(count), 32'h3);
    #1 rst_n = 1'b0;
    #1;
    chk("lit_arst_valid", 32'(out_valid), 32'h0);
    chk("lit_arst_count", 32'(count), 32'h0);
    #5 rst_n = 1'b1;
    tick();
    put(16'h00AA, 1'b0, 1'b0);
    chk("lit_arst_data", 32'(out_data), 32'h00AA);
    drain(1);
    repeat (2) tick();

    chk("no_beef", 32'(saw_beef), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, as the result data width.
REQ-002 The block SHALL take parameter DEPTH, default 4, as the number of FIFO entries; legal values are powers of two, at least 2.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1: the ALU result on in_data/in_carry/in_ovf is offered.
REQ-006 Port in_ready, output, 1: the buffer accepts an offered result this cycle.
REQ-007 Port in_data, input, WIDTH: ALU result word.
REQ-008 Port in_carry / in_ovf, input, 1 each: ALU carry-out and signed-overflow for in_data.
REQ-009 Port flush, input, 1: synchronous clear of all stored entries.
REQ-010 Port out_valid, output, 1: the head entry is presented.
REQ-011 Port out_ready, input, 1: the consumer takes the head entry this cycle.
REQ-012 Port out_data, output, WIDTH: head result word.
REQ-013 Port out_flags, output, 4: the head entry flags {Z,N,C,V}, bit3 = Z.
REQ-014 Port count, output, $clog2(DEPTH)+1: the number of stored entries.

Function
REQ-015 A write SHALL occur when in_valid && in_ready are both high at a rising clk edge.
REQ-016 A read SHALL occur when out_valid && out_ready are both high at a rising clk edge.
REQ-017 in_ready SHALL equal (count != DEPTH); it is a registered-state function and SHALL NOT depend on out_ready.
REQ-018 out_valid SHALL equal (count != 0); out_data and out_flags SHALL be driven from the head-entry storage, with no combinational path from in_data.
REQ-019 Write latency: a result written at edge k SHALL be visible at the outputs after edge k if the buffer was empty (one-cycle latency).
REQ-020 On capture, the flags SHALL be stored as follows: Z = (in_data == 0), N = in_data[WIDTH-1], C = in_carry, V = in_ovf.
REQ-021 Entries SHALL leave in write order; the read and write pointers wrap modulo DEPTH.
REQ-022 On a simultaneous read and write with 0 < count < DEPTH, count SHALL be unchanged and both pointers advance.
REQ-023 When full, a write is blocked by in_ready=0; a read in the same cycle SHALL NOT let the blocked write through.
REQ-024 When empty, a write and an out_ready in the same cycle SHALL NOT read; the new entry appears the next cycle.
REQ-025 flush SHALL take priority over a write or read in the same cycle: count and both pointers go to 0, and the in_valid data that cycle is discarded.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_flags SHALL hold stable.
REQ-027 Storage contents need not reset; only the control state resets.

Reset
REQ-028 While rst_n=0, the block SHALL hold count=0, both pointers=0, out_valid=0 and in_ready=1, with out_data and out_flags reading 0.
REQ-029 Reset asserted mid-transfer SHALL discard all entries immediately, without waiting for clk.
REQ-030 After rst_n deasserts, the first write SHALL be accepted on the first clk edge.

Structure
REQ-031 A shared package alu_pkg SHALL hold the flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0 and the default width ALU_W=16.
REQ-032 The Z/N derivation SHALL live in one combinational sub-module, alu_flag_gen, which the ALU top level reuses.
REQ-033 Storage SHALL be a DEPTH x (WIDTH+4) register array with separate read and write pointers and a count register.

Verification
REQ-034 Reset then single write: write in_data=16'h0000, carry=0, ovf=0 -> next cycle out_valid=1, out_data=0, out_flags=4'b1000, count=1.
REQ-035 Fill and order: write 16'h8001 (C=1), 16'h0001, 16'h7FFF (V=1), 16'h1234 with out_ready=0 -> count=4 and in_ready=0; then drain -> data in write order with flags 4'b0110, 4'b0000, 4'b0001, 4'b0000.
REQ-036 Full with simultaneous read and write: at count=4 drive in_valid=1 and out_ready=1 -> the read occurs, the write is blocked, count=3; the write lands the next cycle, count=4.
REQ-037 Steady streaming: with out_ready=1 and in_valid=1 for 10 cycles, data 1..10 -> count stays 1 after the first cycle, and outputs 1..10 appear in order with no gaps.
REQ-038 Flush versus write: at count=2 assert flush and in_valid (data 16'hBEEF) together -> next cycle count=0 and out_valid=0, and 16'hBEEF never appears.
REQ-039 Asynchronous reset mid-stream: at count=3 pulse rst_n low between clock edges -> out_valid=0 and count=0 immediately; after release, one write of 16'h00AA gives out_data=16'h00AA.
